// File: rtl/spi_master_avalon_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_avalon_if
// Description : Avalon-MM slave bus bundle for the SPI master register block.
//               slave modport  - seen by spi_master_avalon
//               master modport - seen by the CPU side / bench
// Ports       : address[1:0], chipselect, write_n, read_n, writedata[31:0],
//               readdata[31:0] (combinational, zero wait states)
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_avalon_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );
endinterface
`default_nettype wire

// File: rtl/spi_master_avalon.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_avalon
// Description : Avalon-MM slave SPI master, mode 0 (CPOL=0, CPHA=0).
//               Software writes TXDATA to start a transfer, polls STATUS and
//               reads RXDATA. Data is shifted MSB first.
// Ports       : clk, reset_n (async, active-low)
//               bus   - spi_master_avalon_if.slave register port
//               sclk, mosi, ss_n (outputs), miso (input)
//               irq   - only when SPI_MASTER_IRQ_EN is defined
// Registers   : 0 TXDATA (W), 1 RXDATA (R), 2 STATUS {wr_err,rx_valid,busy},
//               3 CONTROL {irq_en@16 (optional), div[DIV_W-1:0]}
// Options     : `define SPI_MASTER_IRQ_EN adds irq output and CONTROL.irq_en
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_avalon #(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 4
) (
  input  wire                 clk,
  input  wire                 reset_n,
  spi_master_avalon_if.slave  bus,
  output logic                sclk,
  output logic                mosi,
  output logic                ss_n,
  input  wire                 miso
`ifdef SPI_MASTER_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    cnt, cnt_nxt;
  logic [BW-1:0]       bit_cnt, bit_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic                sclk_nxt, mosi_nxt, ss_n_nxt;
  logic                done;

  logic [DIV_W-1:0]    div;
  logic [DATA_W-1:0]   rx_data;
  logic                rx_valid;
  logic                wr_err;
  logic                irq_en;

  logic                wr, rd, busy, start, tick;

  assign wr    = bus.chipselect & ~bus.write_n;
  assign rd    = bus.chipselect & ~bus.read_n;
  assign busy  = (state != IDLE);
  assign start = wr && (bus.address == 2'd0) && !busy;
  assign tick  = (cnt == '0);

  // Only the low DATA_W / DIV_W bits of writedata are used.
  wire unused_wdata = &{1'b0, bus.writedata};

  // --------------------------------------------------------------------------
  // Transfer FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ss_n    <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      sclk    <= sclk_nxt;
      mosi    <= mosi_nxt;
      ss_n    <= ss_n_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Transfer FSM: next state and pin values
  // Each non-idle state lasts div+1 cycles; the down-counter is reloaded
  // with div on every state change and the state advances when it hits 0.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    sclk_nxt  = sclk;
    mosi_nxt  = mosi;
    ss_n_nxt  = ss_n;
    done      = 1'b0;

    if (busy) cnt_nxt = tick ? div : cnt - DIV_W'(1);

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          cnt_nxt   = div;
          bit_nxt   = BW'(DATA_W - 1);
          shreg_nxt = bus.writedata[DATA_W-1:0];
          mosi_nxt  = bus.writedata[DATA_W-1];
          ss_n_nxt  = 1'b0;
          sclk_nxt  = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_nxt = HIGH;
          sclk_nxt  = 1'b1;
          shreg_nxt = {shreg[DATA_W-2:0], miso};
        end
      end
      HIGH: begin
        if (tick) begin
          state_nxt = LOW;
          sclk_nxt  = 1'b0;
          // After the sampling shift, the MSB holds the next bit to send.
          if (bit_cnt != '0) mosi_nxt = shreg[DATA_W-1];
        end
      end
      LOW: begin
        if (tick) begin
          if (bit_cnt != '0) begin
            state_nxt = HIGH;
            sclk_nxt  = 1'b1;
            shreg_nxt = {shreg[DATA_W-2:0], miso};
            bit_nxt   = bit_cnt - BW'(1);
          end else begin
            state_nxt = IDLE;
            ss_n_nxt  = 1'b1;
            mosi_nxt  = 1'b0;
            done      = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register block
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div      <= DIV_W'(DIV_RESET);
      rx_data  <= '0;
      rx_valid <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      if (done) rx_data <= shreg;

      // Completion wins over a coincident RXDATA read.
      if (done)                                rx_valid <= 1'b1;
      else if (rd && (bus.address == 2'd1))    rx_valid <= 1'b0;

      if (wr && busy && ((bus.address == 2'd0) || (bus.address == 2'd3)))
        wr_err <= 1'b1;
      else if (wr && (bus.address == 2'd2) && bus.writedata[2])
        wr_err <= 1'b0;

      if (wr && !busy && (bus.address == 2'd3))
        div <= bus.writedata[DIV_W-1:0];
    end
  end

`ifdef SPI_MASTER_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr && !busy && (bus.address == 2'd3)) irq_en <= bus.writedata[16];
      // Dropped on the read edge itself so irq falls together with rx_valid.
      irq <= irq_en & rx_valid & ~(rd && (bus.address == 2'd1));
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read mux (combinational, zero wait states)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd1: bus.readdata = 32'(rx_data);
      2'd2: bus.readdata = {29'd0, wr_err, rx_valid, busy};
      2'd3: begin
        bus.readdata     = 32'(div);
        bus.readdata[16] = irq_en;
      end
      default: bus.readdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_avalon.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_avalon
// Description : Scoreboard bench for spi_master_avalon. Stimulus pushes
//               expected values; a monitor pops and compares observations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_avalon;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_avalon_if bus();
  logic sclk, mosi, ss_n, miso;
  logic miso_one = 1'b0;
  assign miso = miso_one ? 1'b1 : mosi;
`ifdef SPI_MASTER_IRQ_EN
  logic irq;
`endif

  spi_master_avalon #(.DATA_W(8), .DIV_W(8), .DIV_RESET(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .sclk    (sclk),
    .mosi    (mosi),
    .ss_n    (ss_n),
    .miso    (miso)
`ifdef SPI_MASTER_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  // ---------------- scoreboard ----------------
  string       exp_name_q[$];
  logic [31:0] exp_val_q[$];
  logic [31:0] obs_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mon_act, mon_exp;
  string       mon_name;

  task automatic expect_val(string name, logic [31:0] v);
    exp_name_q.push_back(name);
    exp_val_q.push_back(v);
  endtask

  task automatic observe(logic [31:0] v);
    obs_q.push_back(v);
  endtask

  always @(negedge clk) begin
    while (obs_q.size() > 0) begin
      mon_act = obs_q.pop_front();
      n_cmp++;
      if (exp_val_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_obs: got %h required none", mon_act);
      end else begin
        mon_name = exp_name_q.pop_front();
        mon_exp  = exp_val_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_bad++;
          $display("FAIL %s: got %h required %h", mon_name, mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(logic [1:0] a, logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read_chk(string name, logic [1:0] a, logic [31:0] e);
    expect_val(name, e);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
    #1 observe(bus.readdata);
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    expect_val("idle_timeout", 32'd0);
    while (ss_n !== 1'b1 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    observe(32'(n >= budget));
  endtask

  // Start a transfer and measure ss_n low time, sclk pulses/widths, mosi bits.
  task automatic xfer(logic [7:0] tx, int exp_cyc, logic [31:0] exp_w);
    int cyc, rises, run;
    logic prev;
    logic [7:0] bits, hmin, hmax, lmin, lmax;
    expect_val("ss_low_cycles", 32'(exp_cyc));
    expect_val("sclk_pulses", 32'd8);
    expect_val("sclk_widths", exp_w);
    expect_val("mosi_bits", {24'd0, tx});
    bus_write(2'd0, {24'd0, tx});
    cyc = 0; rises = 0; run = 0; prev = 1'b0; bits = '0;
    hmin = 8'hff; hmax = '0; lmin = 8'hff; lmax = '0;
    while (ss_n === 1'b0 && cyc < 2000) begin
      if (sclk !== prev) begin
        if (prev) begin
          if (8'(run) < hmin) hmin = 8'(run);
          if (8'(run) > hmax) hmax = 8'(run);
        end else begin
          if (8'(run) < lmin) lmin = 8'(run);
          if (8'(run) > lmax) lmax = 8'(run);
        end
        run = 0;
        if (sclk === 1'b1) begin
          rises++;
          bits = {bits[6:0], mosi};
        end
      end
      run++; prev = sclk; cyc++;
      @(posedge clk); #1;
    end
    if (prev) begin
      if (8'(run) < hmin) hmin = 8'(run);
      if (8'(run) > hmax) hmax = 8'(run);
    end else begin
      if (8'(run) < lmin) lmin = 8'(run);
      if (8'(run) > lmax) lmax = 8'(run);
    end
    observe(32'(cyc));
    observe(32'(rises));
    observe({hmin, hmax, lmin, lmax});
    observe({24'd0, bits});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, r;
    logic prev;
    bus.address = '0; bus.writedata = '0; bus.chipselect = 1'b0;
    bus.write_n = 1'b1; bus.read_n = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    expect_val("rst_ss_n", 32'd1);  observe(32'(ss_n));
    expect_val("rst_sclk", 32'd0);  observe(32'(sclk));
    expect_val("rst_mosi", 32'd0);  observe(32'(mosi));
    @(negedge clk); reset_n = 1'b1;
    bus_read_chk("rst_status", 2'd2, 32'h0);
    bus_read_chk("rst_control", 2'd3, 32'd4);
    bus_read_chk("rst_rxdata", 2'd1, 32'h0);

    // Loopback, div=1, 0xA5
    bus_write(2'd3, 32'd1);
    xfer(8'hA5, 34, 32'h02020202);
    bus_read_chk("lb_status", 2'd2, 32'h2);
    bus_read_chk("lb_rxdata", 2'd1, 32'hA5);
    bus_read_chk("lb_status2", 2'd2, 32'h0);

    // miso=1, div=0, 0x3C
    bus_write(2'd3, 32'd0);
    miso_one = 1'b1;
    xfer(8'h3C, 17, 32'h01010101);
    bus_read_chk("m1_status", 2'd2, 32'h2);
    bus_read_chk("m1_rxdata", 2'd1, 32'hFF);
    miso_one = 1'b0;

    // Write while busy
    bus_write(2'd3, 32'd1);
    bus_write(2'd0, 32'h11);
    bus_write(2'd0, 32'h22);
    bus_read_chk("busy_status", 2'd2, 32'h5);
    wait_idle(200);
    bus_read_chk("werr_status", 2'd2, 32'h6);
    bus_read_chk("werr_rxdata", 2'd1, 32'h11);
    bus_write(2'd2, 32'h4);
    bus_read_chk("werr_clr", 2'd2, 32'h0);

    // CONTROL write while busy, then H=8
    bus_write(2'd0, 32'h96);
    bus_write(2'd3, 32'd7);
    wait_idle(200);
    bus_read_chk("ctl_busy_div", 2'd3, 32'd1);
    bus_read_chk("ctl_busy_status", 2'd2, 32'h6);
    bus_write(2'd2, 32'h4);
    bus_read_chk("ctl_rxdata", 2'd1, 32'h96);
    bus_write(2'd3, 32'd7);
    bus_read_chk("ctl_div7", 2'd3, 32'd7);
    xfer(8'h5A, 136, 32'h08080808);
    bus_read_chk("h8_rxdata", 2'd1, 32'h5A);

    // Reset in the middle of bit 3
    bus_write(2'd3, 32'd1);
    bus_write(2'd0, 32'h5A);
    n = 0; r = 0; prev = 1'b0;
    while (r < 5 && n < 200) begin
      @(posedge clk); #1;
      if (sclk === 1'b1 && !prev) r++;
      prev = sclk; n++;
    end
    expect_val("mid_ss_n", 32'd0);  observe(32'(ss_n));
    expect_val("mid_mosi", 32'd1);  observe(32'(mosi));
    @(negedge clk); #2;
    reset_n = 1'b0;
    bus.address = 2'd2; bus.chipselect = 1'b1;
    #1;
    expect_val("arst_ss_n", 32'd1);   observe(32'(ss_n));
    expect_val("arst_sclk", 32'd0);   observe(32'(sclk));
    expect_val("arst_mosi", 32'd0);   observe(32'(mosi));
    expect_val("arst_status", 32'd0); observe(bus.readdata);
    bus.address = 2'd3; #1;
    expect_val("arst_control", 32'd4); observe(bus.readdata);
    bus.chipselect = 1'b0;
    @(negedge clk); reset_n = 1'b1;

`ifdef SPI_MASTER_IRQ_EN
    // irq enabled
    bus_write(2'd3, 32'h0001_0001);
    bus_write(2'd0, 32'h5A);
    wait_idle(200);
    expect_val("irq_at_valid", 32'd0); observe(32'(irq));
    @(posedge clk); #1;
    expect_val("irq_rise", 32'd1);     observe(32'(irq));
    bus_read_chk("irq_rxdata", 2'd1, 32'h5A);
    expect_val("irq_drop", 32'd0);     observe(32'(irq));
    // irq disabled
    bus_write(2'd3, 32'd1);
    bus_write(2'd0, 32'h5A);
    wait_idle(200);
    repeat (3) @(posedge clk);
    #1;
    expect_val("irq_off", 32'd0);      observe(32'(irq));
`endif

    repeat (3) @(negedge clk);
    while (exp_val_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got none required %h", exp_name_q.pop_front(), exp_val_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
